// File: rtl/grf_mp_sb.sv
// grf_mp_sb: multi-port general register file for the decode stage.
// Two write ports (port 1 is the younger writeback and wins on collisions),
// NUM_RD combinational read ports with write-through bypass, and a
// per-register pending scoreboard feeding the hazard/stall unit.
module grf_mp_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          wa0,
    input  logic [DATA_W-1:0]          wd0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          wa1,
    input  logic [DATA_W-1:0]          wd1,
    input  logic [NUM_RD*ADDR_W-1:0]   ra,
    output logic [NUM_RD*DATA_W-1:0]   rd,
    output logic [NUM_RD-1:0]          rbusy,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_addr,
    input  logic                       flush,
    output logic                       any_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;

    // Address 0 is hardwired to zero when ZERO_REG is set.
    logic wr0_ok;
    logic wr1_ok;
    logic wr0_keep;

    assign wr1_ok   = we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign wr0_ok   = we0 && !((ZERO_REG != 0) && (wa0 == '0));
    // Port 1 is younger, so a same-address port 0 write is discarded.
    assign wr0_keep = wr0_ok && !(we1 && (wa1 == wa0));

    // Register array update; reset clears every entry.
    // NOTE: the array is reset because reads must return 0 from every
    // register after reset; this forces flops rather than a RAM macro.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_keep) regs[wa0] <= wd0;
            if (wr1_ok)   regs[wa1] <= wd1;
        end
    end

    // Scoreboard next state: flush > issue > write-clear > hold.
    // NOTE: busy_nxt gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < DEPTH; r++) begin
            if (flush) begin
                busy_nxt[r] = 1'b0;
            end else if (iss_en && (iss_addr == ADDR_W'(r))) begin
                busy_nxt[r] = 1'b1;
            end else if ((we0 && (wa0 == ADDR_W'(r))) ||
                         (we1 && (wa1 == ADDR_W'(r)))) begin
                busy_nxt[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign any_busy = |busy;

    // Per-port read mux with bypass, and bypass-adjusted busy flag.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic              is_zero;
        logic              hit0;
        logic              hit1;

        assign raddr   = ra[k*ADDR_W +: ADDR_W];
        assign is_zero = (ZERO_REG != 0) && (raddr == '0);
        assign hit1    = we1 && (wa1 == raddr);
        assign hit0    = we0 && (wa0 == raddr);

        assign rd[k*DATA_W +: DATA_W] = is_zero ? '0  :
                                        hit1    ? wd1 :
                                        hit0    ? wd0 :
                                                  regs[raddr];
        assign rbusy[k] = busy[raddr] && !hit0 && !hit1 && !is_zero;
    end

endmodule
